// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO stream reader and its output buffer.
package fifo_reader_pkg;

    // Reader operating mode.
    typedef enum logic {
        StRun   = 1'b0,
        StFlush = 1'b1
    } state_e;

    // Output buffer depth; three entries cover the read issue plus data cycles.
    localparam int unsigned BUF_DEPTH = 3;
    localparam int unsigned BUF_CNT_W = $clog2(BUF_DEPTH + 1);

    typedef logic [BUF_CNT_W-1:0] buf_cnt_t;

endpackage

// File: rtl/stream_out_buf.sv
// Small FIFO-order output buffer; entry 0 is always the head so a stalled head never moves.
module stream_out_buf
    import fifo_reader_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output buf_cnt_t         cnt_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [WIDTH-1:0] mem_d [BUF_DEPTH];
    buf_cnt_t         cnt_q;
    buf_cnt_t         cnt_d;
    buf_cnt_t         base;
    logic             pop_ok;

    assign pop_ok = pop_i && (cnt_q != '0);

    // Next-state: shift on pop, then write the pushed word just past the remaining entries.
    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        base  = cnt_q - buf_cnt_t'(pop_ok);
        if (clear_i) begin
            cnt_d = '0;
        end else begin
            if (pop_ok) begin
                for (int unsigned i = 0; i < BUF_DEPTH - 1; i++) begin
                    mem_d[i] = mem_q[i+1];
                end
            end
            if (push_i && (base < buf_cnt_t'(BUF_DEPTH))) begin
                mem_d[base] = data_i;
                cnt_d       = base + 1'b1;
            end else begin
                cnt_d = base;
            end
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign head_o = mem_q[0];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: turns empty/read_en/registered data into a
// valid/ready stream, with a flush mode that drains and discards the FIFO.
module fifo_stream_reader
    import fifo_reader_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_data_i,
    output logic             fifo_read_en_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o,
    input  logic             flush_i,
    output logic             flush_done_o,
    output logic [CNT_W-1:0] words_out_o,
    output logic [CNT_W-1:0] words_dropped_o
);

    localparam int unsigned OccW = BUF_CNT_W + 1;

    state_e           state_q;
    state_e           state_d;
    logic             inflight_q;
    logic             read_en;
    logic [CNT_W-1:0] words_out_q;
    logic [CNT_W-1:0] words_out_d;
    logic [CNT_W-1:0] dropped_q;
    logic [CNT_W-1:0] dropped_d;
    buf_cnt_t         buf_cnt;
    logic [WIDTH-1:0] buf_head;
    logic [OccW-1:0]  occupancy;
    logic             push;
    logic             pop;
    logic             flushing;

    assign flushing  = (state_q == StFlush);
    // Words already buffered plus the one in flight; a read is only issued if it has a slot.
    assign occupancy = OccW'(buf_cnt) + OccW'(inflight_q);
    assign m_valid_o = !flushing && (buf_cnt != '0);
    assign pop       = m_valid_o && m_ready_i;
    assign push      = inflight_q && !flushing;
    assign m_data_o  = buf_head;

    // Read enable is gated by reset so the FIFO sees no request while it is held in reset.
    assign fifo_read_en_o = rst_n && read_en;

    stream_out_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (fifo_data_i),
        .pop_i   (pop),
        .clear_i (flushing),
        .cnt_o   (buf_cnt),
        .head_o  (buf_head)
    );

    // Mode transitions, read issue, flush completion and counter updates.
    always_comb begin
        state_d      = state_q;
        read_en      = 1'b0;
        flush_done_o = 1'b0;
        words_out_d  = words_out_q + CNT_W'(pop);
        dropped_d    = dropped_q;
        case (state_q)
            StRun: begin
                read_en = !fifo_empty_i && (occupancy < OccW'(BUF_DEPTH));
                if (flush_i) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                read_en = !fifo_empty_i;
                // Buffered words are cleared on the first flush cycle; in-flight words each cycle.
                dropped_d = dropped_q + CNT_W'(buf_cnt) + CNT_W'(inflight_q);
                if (fifo_empty_i && !inflight_q) begin
                    flush_done_o = 1'b1;
                    state_d      = StRun;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // Mode, in-flight tracking and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            inflight_q  <= 1'b0;
            words_out_q <= '0;
            dropped_q   <= '0;
        end else begin
            state_q     <= state_d;
            inflight_q  <= fifo_read_en_o;
            words_out_q <= words_out_d;
            dropped_q   <= dropped_d;
        end
    end

    assign words_out_o     = words_out_q;
    assign words_dropped_o = dropped_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO, queue-level reference model, directed tests.
module tb_fifo_stream_reader;

    localparam int unsigned WIDTH = 3;
    localparam int unsigned CNT_W = 4;
    localparam int          WRAP  = 1 << CNT_W;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b0;
    logic             fifo_empty = 1'b1;
    logic [WIDTH-1:0] fifo_data  = '0;
    logic             m_ready    = 1'b0;
    logic             flush      = 1'b0;
    logic             fifo_read_en;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             flush_done;
    logic [CNT_W-1:0] words_out;
    logic [CNT_W-1:0] words_dropped;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural FIFO contents.
    int fq[$];
    // Reference model: words held by the reader, in-flight word, mode and event totals.
    int mq[$];
    bit m_infl      = 1'b0;
    int m_infl_word = 0;
    bit m_flushing  = 1'b0;
    int n_out       = 0;
    int n_drop      = 0;
    // Per-cycle samples taken mid-cycle, consumed at the following rising edge.
    bit c_rst   = 1'b0;
    bit c_ready = 1'b0;
    bit c_flush = 1'b0;
    bit c_valid = 1'b0;
    bit c_rd    = 1'b0;
    bit c_done  = 1'b0;
    // Event monitor.
    int cyc         = 0;
    int rd_events   = 0;
    int done_events = 0;
    int rd_cyc[$];
    int hs_log[$];
    int hs_cyc[$];
    int exp_q[$];

    fifo_stream_reader #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fifo_empty_i    (fifo_empty),
        .fifo_data_i     (fifo_data),
        .fifo_read_en_o  (fifo_read_en),
        .m_valid_o       (m_valid),
        .m_ready_i       (m_ready),
        .m_data_o        (m_data),
        .flush_i         (flush),
        .flush_done_o    (flush_done),
        .words_out_o     (words_out),
        .words_dropped_o (words_dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Mid-cycle: derive expected outputs from the model, compare, and log events.
    always @(negedge clk) begin
        c_rst   = rst_n;
        c_ready = m_ready;
        c_flush = flush;
        c_valid = rst_n && !m_flushing && (mq.size() > 0);
        c_rd    = rst_n && !fifo_empty && (m_flushing || (mq.size() + int'(m_infl) < 3));
        c_done  = rst_n && m_flushing && fifo_empty && !m_infl;
        chk("m_valid", int'(m_valid), int'(c_valid));
        if (c_valid) chk("m_data", int'(m_data), mq[0]);
        chk("fifo_read_en", int'(fifo_read_en), int'(c_rd));
        chk("flush_done", int'(flush_done), int'(c_done));
        chk("words_out", int'(words_out), n_out % WRAP);
        chk("words_dropped", int'(words_dropped), n_drop % WRAP);
        if (fifo_read_en) begin
            rd_events++;
            rd_cyc.push_back(cyc);
        end
        if (m_valid && m_ready) begin
            hs_log.push_back(int'(m_data));
            hs_cyc.push_back(cyc);
        end
        if (flush_done) done_events++;
        cyc++;
    end

    // Rising edge: advance the model, then let the behavioural FIFO answer the read.
    always @(posedge clk) begin
        if (!c_rst) begin
            mq.delete();
            m_flushing = 1'b0;
            n_out      = 0;
            n_drop     = 0;
        end else if (m_flushing) begin
            n_drop = n_drop + mq.size() + int'(m_infl);
            mq.delete();
            if (c_done) m_flushing = 1'b0;
        end else begin
            if (c_valid && c_ready) begin
                void'(mq.pop_front());
                n_out++;
            end
            if (m_infl) mq.push_back(m_infl_word);
            if (c_flush) m_flushing = 1'b1;
        end
        m_infl = c_rd;
        if (c_rd) m_infl_word = fq[0];
        #1;
        if (c_rd) fifo_data = WIDTH'(fq.pop_front());
        fifo_empty = (fq.size() == 0);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wr(input int w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic clear_mon();
        rd_events   = 0;
        done_events = 0;
        rd_cyc.delete();
        hs_log.delete();
        hs_cyc.delete();
    endtask

    task automatic wait_hs(input int n, input int budget, input string name);
        int k = 0;
        while (hs_log.size() < n && k < budget) begin
            step(1);
            k++;
        end
        chk({name, "_beats"}, hs_log.size(), n);
    endtask

    task automatic chk_log(input string name);
        chk({name, "_len"}, hs_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < hs_log.size()) chk(name, hs_log[i], exp_q[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // Reset state.
        step(2);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_read_en", int'(fifo_read_en), 0);
        chk("rst_flush_done", int'(flush_done), 0);
        chk("rst_words_out", int'(words_out), 0);
        chk("rst_words_dropped", int'(words_dropped), 0);
        rst_n = 1'b1;
        step(2);

        // Streaming at full rate.
        clear_mon();
        m_ready = 1'b1;
        wr(3); wr(5); wr(1); wr(7);
        wait_hs(4, 30, "stream");
        step(3);
        exp_q = {3, 5, 1, 7};
        chk_log("stream_data");
        chk("stream_reads", rd_events, 4);
        if (hs_cyc.size() == 4 && rd_cyc.size() > 0) begin
            chk("stream_latency", hs_cyc[0] - rd_cyc[0], 2);
            chk("stream_gapless", hs_cyc[3] - hs_cyc[0], 3);
        end
        chk("stream_words_out", int'(words_out), 4);

        // Backpressure: three reads fill the buffer, head held stable.
        clear_mon();
        m_ready = 1'b0;
        wr(6); wr(2); wr(4); wr(1);
        step(8);
        chk("bp_reads", rd_events, 3);
        for (int i = 0; i < 3; i++) begin
            chk("bp_m_valid", int'(m_valid), 1);
            chk("bp_m_data_hold", int'(m_data), 6);
            step(1);
        end
        m_ready = 1'b1;
        wait_hs(4, 30, "bp");
        step(3);
        exp_q = {6, 2, 4, 1};
        chk_log("bp_data");
        chk("bp_reads_total", rd_events, 4);
        chk("bp_words_out", int'(words_out), 8);

        // Sink toggling ready every cycle.
        clear_mon();
        wr(0); wr(1); wr(2); wr(3); wr(4); wr(5);
        k = 0;
        while (hs_log.size() < 6 && k < 40) begin
            m_ready = ~m_ready;
            step(1);
            k++;
        end
        chk("stall_beats", hs_log.size(), 6);
        m_ready = 1'b1;
        step(3);
        exp_q = {0, 1, 2, 3, 4, 5};
        chk_log("stall_data");
        chk("stall_words_out", int'(words_out), 14);

        // Flush with two words buffered and three in the FIFO.
        clear_mon();
        m_ready = 1'b0;
        wr(5); wr(6);
        step(4);
        wr(1); wr(2); wr(3);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        chk("flush_m_valid", int'(m_valid), 0);
        k = 0;
        while (done_events == 0 && k < 30) begin
            step(1);
            k++;
        end
        step(3);
        chk("flush_done_pulses", done_events, 1);
        chk("flush_dropped", int'(words_dropped), 5);
        chk("flush_reads", rd_events, 5);
        chk("flush_no_beats", hs_log.size(), 0);
        chk("flush_words_out", int'(words_out), 14);

        // Single word into an empty FIFO.
        clear_mon();
        m_ready = 1'b1;
        wr(4);
        step(8);
        chk("edge_reads", rd_events, 1);
        exp_q = {4};
        chk_log("edge_data");
        chk("edge_read_en_idle", int'(fifo_read_en), 0);
        chk("edge_words_out", int'(words_out), 15);

        // Delivered-word counter wraps.
        clear_mon();
        wr(7); wr(0); wr(3);
        wait_hs(3, 30, "wrap");
        step(2);
        exp_q = {7, 0, 3};
        chk_log("wrap_data");
        chk("wrap_words_out", int'(words_out), 2);
        chk("wrap_words_dropped", int'(words_dropped), 5);

        // Asynchronous reset in the middle of a stream.
        clear_mon();
        for (int i = 1; i <= 8; i++) wr(i % 8);
        step(4);
        chk("arst_streaming", int'(hs_log.size() > 0), 1);
        rst_n      = 1'b0;
        mq.delete();
        m_infl     = 1'b0;
        m_flushing = 1'b0;
        n_out      = 0;
        n_drop     = 0;
        fq.delete();
        fifo_empty = 1'b1;
        #1;
        chk("arst_m_valid", int'(m_valid), 0);
        chk("arst_read_en", int'(fifo_read_en), 0);
        chk("arst_m_data", int'(m_data), 0);
        chk("arst_words_out", int'(words_out), 0);
        chk("arst_words_dropped", int'(words_dropped), 0);
        step(3);
        rst_n = 1'b1;
        step(2);
        clear_mon();
        wr(3); wr(5); wr(1); wr(7);
        wait_hs(4, 30, "resume");
        step(3);
        exp_q = {3, 5, 1, 7};
        chk_log("resume_data");
        chk("resume_words_out", int'(words_out), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
